// File: rtl/ysyx_exu_trap.sv
// ysyx_exu_trap -- trap / mret sequencer between the EXU and the CSR file.
//
// A trap request (ecall, exception, mret, interrupt) is accepted in IDLE.
// The block then spends one COMMIT cycle writing the CSR file and capturing
// the redirect target. After that it stays in REDIRECT until the IFU takes
// the new PC.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    trap-request handshake from the EXU (ready only in IDLE)
//   req_kind           0 ecall, 1 exception, 2 mret, 3 interrupt
//   req_pc, req_cause  faulting/resume PC and exception/interrupt code
//   mtvec_i, mepc_i, mstatus_i  current CSR values, sampled during COMMIT
//   csr_*              dual-port CSR write request, live only during COMMIT
//   redir_valid/ready, redir_pc  PC redirect handshake to the IFU
//   busy               high whenever a trap is in flight
//
// Configuration macro
//   YSYX_TRAP_VECTORED_EN  when defined, an interrupt with mtvec mode 1
//                          vectors to base + 4*cause. Otherwise every trap
//                          goes to base (direct mode).

`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_exu_trap #(
  parameter int BIT_W = `YSYX_W_WIDTH,
  parameter int R_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [BIT_W-1:0] req_pc,
  input  logic [BIT_W-1:0] req_cause,
  input  logic [BIT_W-1:0] mtvec_i,
  input  logic [BIT_W-1:0] mepc_i,
  input  logic [BIT_W-1:0] mstatus_i,
  output logic             csr_wen,
  output logic             csr_valid,
  output logic             csr_ecallen,
  output logic [R_W-1:0]   csr_waddr,
  output logic [R_W-1:0]   csr_waddr_add1,
  output logic [BIT_W-1:0] csr_wdata,
  output logic [BIT_W-1:0] csr_wdata_add1,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [BIT_W-1:0] redir_pc,
  output logic             busy
);

  localparam logic [1:0] KIND_ECALL = 2'd0;
  localparam logic [1:0] KIND_EXC   = 2'd1;
  localparam logic [1:0] KIND_MRET  = 2'd2;
  localparam logic [1:0] KIND_INTR  = 2'd3;

  localparam logic [R_W-1:0] ADDR_MSTATUS = R_W'(12'h300);
  localparam logic [R_W-1:0] ADDR_MEPC    = R_W'(12'h341);
  localparam logic [R_W-1:0] ADDR_MCAUSE  = R_W'(12'h342);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       kind_q;
  logic [BIT_W-1:0] pc_q;
  logic [BIT_W-1:0] cause_q;
  logic [BIT_W-1:0] redir_pc_q;
  logic [BIT_W-1:0] target;

  // The MSB of the cause is replaced by the interrupt flag. The mtvec mode
  // bits are dropped when vectoring is compiled out.
  logic unused_bits;
  assign unused_bits = ^{cause_q[BIT_W-1], mtvec_i[1:0]};

  // Build the mcause value. An ecall always reports 11. Otherwise the MSB
  // flags whether this is an interrupt.
  function automatic logic [BIT_W-1:0] mcause_of(input logic [1:0]       kind,
                                                 input logic [BIT_W-1:0] cause);
    logic [BIT_W-1:0] r;
    case (kind)
      KIND_ECALL: r = BIT_W'(11);
      KIND_INTR:  r = {1'b1, cause[BIT_W-2:0]};
      default:    r = {1'b0, cause[BIT_W-2:0]};
    endcase
    return r;
  endfunction

  // mret: MIE <- MPIE, MPIE <- 1. All other bits pass through.
  function automatic logic [BIT_W-1:0] mret_mstatus(input logic [BIT_W-1:0] ms);
    logic [BIT_W-1:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Redirect target. Mode values 2 and 3 fall back to direct mode.
  function automatic logic [BIT_W-1:0] trap_target(input logic [1:0]       kind,
                                                   input logic [BIT_W-1:0] cause,
                                                   input logic [BIT_W-1:0] mtvec,
                                                   input logic [BIT_W-1:0] mepc);
    logic [BIT_W-1:0] base;
    logic [BIT_W-1:0] r;
    base = {mtvec[BIT_W-1:2], 2'b00};
    r    = base;
    if (kind == KIND_MRET) begin
      r = mepc;
    end
`ifdef YSYX_TRAP_VECTORED_EN
    else if (kind == KIND_INTR && mtvec[1:0] == 2'b01) begin
      // 4*cause modulo 2^BIT_W: the top cause bits shift out.
      r = base + {cause[BIT_W-3:0], 2'b00};
    end
`endif
    return r;
  endfunction

  assign target = trap_target(kind_q, cause_q, mtvec_i, mepc_i);

  // State, request latch and redirect-PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kind_q     <= 2'd0;
      pc_q       <= '0;
      cause_q    <= '0;
      redir_pc_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        kind_q  <= req_kind;
        pc_q    <= req_pc;
        cause_q <= req_cause;
      end
      if (state == COMMIT) begin
        redir_pc_q <= target;
      end
    end
  end

  // Next state and outputs. Reset overrides everything combinationally, so
  // outputs are already quiet during the reset cycle itself.
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    csr_wen        = 1'b0;
    csr_valid      = 1'b0;
    csr_ecallen    = 1'b0;
    csr_waddr      = '0;
    csr_waddr_add1 = '0;
    csr_wdata      = '0;
    csr_wdata_add1 = '0;
    redir_valid    = 1'b0;
    redir_pc       = redir_pc_q;
    busy           = (state != IDLE);

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = COMMIT;
      end
      COMMIT: begin
        csr_wen   = 1'b1;
        csr_valid = 1'b1;
        if (kind_q == KIND_MRET) begin
          csr_waddr = ADDR_MSTATUS;
          csr_wdata = mret_mstatus(mstatus_i);
        end else begin
          csr_ecallen    = 1'b1;
          csr_waddr      = ADDR_MEPC;
          csr_wdata      = {pc_q[BIT_W-1:2], 2'b00};
          csr_waddr_add1 = ADDR_MCAUSE;
          csr_wdata_add1 = mcause_of(kind_q, cause_q);
        end
        state_nxt = REDIRECT;
      end
      REDIRECT: begin
        redir_valid = 1'b1;
        if (redir_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      state_nxt      = IDLE;
      req_ready      = 1'b1;
      csr_wen        = 1'b0;
      csr_valid      = 1'b0;
      csr_ecallen    = 1'b0;
      csr_waddr      = '0;
      csr_waddr_add1 = '0;
      csr_wdata      = '0;
      csr_wdata_add1 = '0;
      redir_valid    = 1'b0;
      redir_pc       = '0;
      busy           = 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_exu_trap.sv
// Bench for ysyx_exu_trap. The stimulus pushes the expected CSR write and
// redirect into queues. A negedge monitor pops and compares them.
module tb_ysyx_exu_trap;
  localparam int BIT_W = 32;
  localparam int R_W   = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_kind = 2'd0;
  logic [BIT_W-1:0] req_pc = '0, req_cause = '0;
  logic [BIT_W-1:0] mtvec_i = '0, mepc_i = '0, mstatus_i = '0;
  logic             csr_wen, csr_valid, csr_ecallen;
  logic [R_W-1:0]   csr_waddr, csr_waddr_add1;
  logic [BIT_W-1:0] csr_wdata, csr_wdata_add1;
  logic             redir_valid;
  logic             redir_ready = 1'b0;
  logic [BIT_W-1:0] redir_pc;
  logic             busy;

  ysyx_exu_trap #(.BIT_W(BIT_W), .R_W(R_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_pc(req_pc), .req_cause(req_cause),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
    .csr_wen(csr_wen), .csr_valid(csr_valid), .csr_ecallen(csr_ecallen),
    .csr_waddr(csr_waddr), .csr_waddr_add1(csr_waddr_add1),
    .csr_wdata(csr_wdata), .csr_wdata_add1(csr_wdata_add1),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic        ecl;
  } csr_exp_t;
  typedef struct {
    int          at;
    logic [31:0] pc;
  } red_exp_t;

  csr_exp_t csr_q[$];
  red_exp_t red_q[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, a, e, cyc);
  endtask

  // Reference model, computed directly from the trap rules.
  function automatic void model(input logic [1:0] k, input logic [31:0] pc, cause,
                                input logic [31:0] mtvec, mepc, ms,
                                output csr_exp_t ce, output logic [31:0] tgt);
    logic [31:0] mcause;
    ce.at = 0;
    case (k)
      2'd0:    mcause = 32'd11;
      2'd3:    mcause = cause | 32'h8000_0000;
      default: mcause = cause & 32'h7fff_ffff;
    endcase
    if (k == 2'd2) begin
      ce.a0  = 12'h300;
      ce.d0  = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
      ce.a1  = 12'h000;
      ce.d1  = 32'h0;
      ce.ecl = 1'b0;
      tgt    = mepc;
    end else begin
      ce.a0  = 12'h341;
      ce.d0  = pc & ~32'h3;
      ce.a1  = 12'h342;
      ce.d1  = mcause;
      ce.ecl = 1'b1;
      tgt    = mtvec & ~32'h3;
`ifdef YSYX_TRAP_VECTORED_EN
      if (k == 2'd3 && (mtvec % 4) == 1)
        tgt = (mtvec & ~32'h3) + (cause & 32'h7fff_ffff) * 32'd4;
`endif
    end
  endfunction

  // redir_ready driver: forced low while stall > 0, else by mode.
  int rr_mode = 1;  // 0 random, 1 tied high, 2 tied low
  int stall = 0;
  always @(posedge clk) begin
    #2;
    if (stall > 0) begin
      redir_ready = 1'b0;
      stall--;
    end else if (rr_mode == 1) redir_ready = 1'b1;
    else if (rr_mode == 2) redir_ready = 1'b0;
    else redir_ready = 1'($urandom);
  end

  task automatic issue(input logic [1:0] k, input logic [31:0] pc, cause,
                       input logic [31:0] mtvec, mepc, ms);
    int n;
    csr_exp_t ce;
    red_exp_t re;
    logic [31:0] t;
    n = 0;
    req_valid = 1'b1; req_kind = k; req_pc = pc; req_cause = cause;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL accept_timeout actual=req_ready 0 required=1 (cycle %0d)", cyc);
      req_valid = 1'b0;
      return;
    end
    mtvec_i = mtvec; mepc_i = mepc; mstatus_i = ms;
    model(k, pc, cause, mtvec, mepc, ms, ce, t);
    ce.at = cyc + 1;
    re.at = cyc + 2;
    re.pc = t;
    csr_q.push_back(ce);
    red_q.push_back(re);
    @(posedge clk); #1;
    // Scramble the request bus so a late re-latch would be visible.
    req_valid = 1'b0;
    req_kind  = 2'($urandom);
    req_pc    = $urandom;
    req_cause = $urandom;
  endtask

  // Monitor
  logic        in_red = 1'b0;
  logic [31:0] red_hold = '0;
  int          ready_due = -1;
  csr_exp_t    ce_m;
  red_exp_t    re_m;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_ctrl", 64'({csr_wen, csr_valid, csr_ecallen, redir_valid, busy}), 64'd0);
      chk("rst_data", 64'(|{csr_waddr, csr_waddr_add1, csr_wdata, csr_wdata_add1, redir_pc}), 64'd0);
      csr_q.delete();
      red_q.delete();
      in_red    = 1'b0;
      ready_due = -1;
    end else begin
      chk("busy_vs_ready", 64'(busy), 64'(!req_ready));
      if (ready_due == cyc) chk("ready_after_redir", 64'(req_ready), 64'd1);
      if (csr_wen) begin
        if (csr_q.size() == 0) begin
          n_chk++;
          $display("FAIL csr_unexpected actual=wen 1 required=0 (cycle %0d)", cyc);
        end else begin
          ce_m = csr_q.pop_front();
          chk("csr_cycle", 64'(cyc), 64'(ce_m.at));
          chk("csr_valid", 64'(csr_valid), 64'd1);
          chk("csr_ecallen", 64'(csr_ecallen), 64'(ce_m.ecl));
          chk("csr_waddr", 64'(csr_waddr), 64'(ce_m.a0));
          chk("csr_wdata", 64'(csr_wdata), 64'(ce_m.d0));
          chk("csr_waddr_add1", 64'(csr_waddr_add1), 64'(ce_m.a1));
          chk("csr_wdata_add1", 64'(csr_wdata_add1), 64'(ce_m.d1));
        end
      end else begin
        chk("csr_idle", 64'(|{csr_valid, csr_ecallen, csr_waddr, csr_waddr_add1,
                               csr_wdata, csr_wdata_add1}), 64'd0);
      end
      if (redir_valid) begin
        chk("redir_busy_ready", 64'({busy, req_ready}), 64'b10);
        if (!in_red) begin
          if (red_q.size() == 0) begin
            n_chk++;
            $display("FAIL redir_unexpected actual=valid 1 required=0 (cycle %0d)", cyc);
          end else begin
            re_m = red_q.pop_front();
            chk("redir_cycle", 64'(cyc), 64'(re_m.at));
            chk("redir_pc", 64'(redir_pc), 64'(re_m.pc));
          end
          red_hold = redir_pc;
          in_red   = 1'b1;
        end else begin
          chk("redir_stable", 64'(redir_pc), 64'(red_hold));
        end
        if (redir_ready) begin
          in_red    = 1'b0;
          ready_due = cyc + 1;
        end
      end else if (in_red) begin
        n_chk++;
        $display("FAIL redir_dropped actual=valid 0 required=1 (cycle %0d)", cyc);
        in_red = 1'b0;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((csr_q.size() != 0 || red_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases with redir_ready tied high (back-to-back timing).
    rr_mode = 1;
    issue(2'd0, 32'h8000_0100, 32'h0000_1234, 32'h8000_0000, 32'h8000_0104, 32'h0);
    issue(2'd2, 32'h0000_0000, 32'h0,         32'h8000_0000, 32'h8000_0104, 32'h0000_1880);
    issue(2'd3, 32'h8000_0044, 32'd7,         32'h8000_0001, 32'h0,         32'h0);
    issue(2'd1, 32'h8000_0203, 32'h8000_0002, 32'h8000_0003, 32'h0,         32'h0);
    issue(2'd3, 32'h1,         32'hC000_0001, 32'h8000_0002, 32'h0,         32'h0);

    // Stalled redirect while another request waits on the bus.
    stall = 6;
    issue(2'd1, 32'h1234_5679, 32'd5, 32'h0000_4000, 32'h0, 32'h0);
    issue(2'd0, 32'h2222_2222, 32'd9, 32'h0000_8000, 32'h0, 32'h0);

    // Randomized traffic with random redir_ready.
    rr_mode = 0;
    for (int i = 0; i < 200; i++)
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, $urandom);
    drain();

    // Reset while parked in REDIRECT.
    rr_mode = 2;
    issue(2'd0, 32'h8000_0100, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rr_mode = 1;
    repeat (2) @(posedge clk);
    #1;

    // Reset during the COMMIT cycle: the CSR write must not appear.
    issue(2'd2, 32'h0, 32'h0, 32'h0, 32'h8000_0104, 32'h0000_1880);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Recovery.
    issue(2'd3, 32'h0, 32'd3, 32'h8000_0001, 32'h0, 32'h0);
    drain();

    if (csr_q.size() != 0 || red_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", csr_q.size(), red_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ysyx_exu_trap.md
YSYX_EXU_TRAP -- requirements
Module: ysyx_exu_trap

Interface
REQ-001 The block SHALL have parameter BIT_W, default `YSYX_W_WIDTH (32), meaning data/address width.
REQ-002 The block SHALL have parameter R_W, default 12, meaning CSR address width.
REQ-003 The block SHALL have port clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 The block SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have ports req_valid in 1, req_ready out 1: trap-request handshake from EXU.
REQ-006 The block SHALL have port req_kind  in  2: 0 ecall, 1 exception, 2 mret, 3 interrupt.
REQ-007 The block SHALL have ports req_pc in BIT_W (faulting/resume PC) and req_cause in BIT_W (exception/interrupt code).
REQ-008 The block SHALL have ports mtvec_i, mepc_i, mstatus_i  in  BIT_W: current CSR values from the CSR file.
REQ-009 The block SHALL have outputs csr_wen 1, csr_valid 1, csr_ecallen 1, csr_waddr R_W, csr_waddr_add1 R_W, csr_wdata BIT_W, csr_wdata_add1 BIT_W: dual-port CSR write request.
REQ-010 The block SHALL have ports redir_valid out 1, redir_ready in 1, redir_pc out BIT_W: PC redirect handshake to IFU; busy out 1 (state != IDLE).

Function
REQ-011 FSM states SHALL be IDLE, COMMIT, REDIRECT; req_ready = 1 only in IDLE.
REQ-012 IDLE SHALL move to COMMIT when req_valid & req_ready, latching req_kind, req_pc, req_cause.
REQ-013 COMMIT SHALL last exactly one cycle, pulse csr_wen = csr_valid = 1, register redir_pc, then go to REDIRECT.
REQ-014 For ecall/exception/interrupt, COMMIT SHALL drive csr_waddr 0x341 with wdata = latched pc with bits[1:0] cleared, csr_waddr_add1 0x342 with wdata_add1 = mcause, csr_ecallen = 1.
REQ-015 mcause SHALL be 11 for ecall (req_cause ignored), {1'b0, req_cause[BIT_W-2:0]} for exception, {1'b1, req_cause[BIT_W-2:0]} for interrupt.
REQ-016 For mret, COMMIT SHALL drive csr_waddr 0x300 with wdata = mstatus_i with bit3 (MIE) = mstatus_i[7], bit7 (MPIE) = 1, other bits unchanged; csr_waddr_add1 0x000, wdata_add1 0; csr_ecallen = 0.
REQ-017 Trap target SHALL be {mtvec_i[BIT_W-1:2], 2'b00} sampled in COMMIT; mret target SHALL be mepc_i sampled in COMMIT.
REQ-018 REDIRECT SHALL hold redir_valid = 1 and redir_pc stable until redir_ready; on redir_valid & redir_ready go to IDLE next cycle.
REQ-019 Latency: request accepted cycle N -> CSR write cycle N+1 -> redir_valid from N+2; with redir_ready = 1 at N+2, req_ready = 1 at N+3.
REQ-020 Outside COMMIT, csr_wen, csr_valid, csr_ecallen SHALL be 0 and csr_* addresses/data 0.
REQ-021 req_valid in COMMIT or REDIRECT SHALL be ignored (not accepted, not lost-latched); requester holds it.
REQ-022 mtvec_i mode values 2/3 SHALL be treated as direct mode.

Reset
REQ-023 rst SHALL force IDLE from any state, including mid-COMMIT/REDIRECT, abandoning the trap.
REQ-024 During and after reset all outputs SHALL be 0 except req_ready = 1; latched fields 0.

Configuration
REQ-025 Macro YSYX_TRAP_VECTORED_EN defined: when kind = interrupt and mtvec_i[1:0] = 1, target SHALL be base + 4*req_cause[BIT_W-2:0] (modulo 2^BIT_W).
REQ-026 Macro undefined: all traps SHALL use base (direct mode) regardless of mtvec_i[1:0].

Verification
REQ-027 ecall pc 0x80000100, mtvec_i 0x80000000 -> N+1: wen, 0x341<=0x80000100, 0x342<=0x0000000B, ecallen=1; N+2: redir_pc 0x80000000.
REQ-028 mret, mepc_i 0x80000104, mstatus_i 0x00001880 -> N+1: 0x300<=0x00001888, add1 0x000<=0; N+2: redir_pc 0x80000104.
REQ-029 interrupt cause 7, mtvec_i 0x80000001 -> mcause 0x80000007; redir_pc 0x8000001C with macro, 0x80000000 without.
REQ-030 redir_ready low 3 cycles -> redir_valid/redir_pc stable, req_ready 0, concurrent req_valid not accepted; accepted after handshake.
REQ-031 rst asserted in REDIRECT -> next cycle redir_valid 0, busy 0, req_ready 1, no CSR write.
REQ-032 back-to-back requests with redir_ready tied 1 -> second accepted at N+3, CSR writes at N+1 and N+4 only.
